// File: rtl/mux_2_to_1.sv
// 2:1 word multiplexer with a combinational output and a registered copy.
// y is independent of clk/rst; y_q/sel_q capture the same selection one edge later.
module mux_2_to_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_q
);

    logic [WIDTH-1:0] y_d;
    logic             sel_d;

    assign y     = sel ? b : a;
    assign y_d   = y;
    assign sel_d = sel;

    // Async reset clears the registered copy without waiting for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q   <= '0;
            sel_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: tb/tb_mux_2_to_1.sv
// Bench for mux_2_to_1: directed corner cases followed by random traffic
// checked against a reference selection/capture model.
module tb_mux_2_to_1;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             sel_q;

    int n_chk;
    int n_err;

    // Reference state: what the registered outputs should hold right now.
    logic [WIDTH-1:0] m_yq;
    logic             m_selq;

    mux_2_to_1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .y     (y),
        .y_q   (y_q),
        .sel_q (sel_q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] xa,
                                              input logic [WIDTH-1:0] xb,
                                              input logic xs);
        logic [WIDTH-1:0] r;
        r = xa;
        if (xs == 1'b1) r = xb;
        return r;
    endfunction

    // One full clock period; returns with clk low, well away from the rising edge.
    task automatic tick();
        #5 clk = 1'b1;
        if (rst) begin
            m_yq   = '0;
            m_selq = 1'b0;
        end else begin
            m_yq   = pick(a, b, sel);
            m_selq = sel;
        end
        #5 clk = 1'b0;
    endtask

    task automatic reset_model();
        m_yq   = '0;
        m_selq = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        clk   = 1'b0;

        // Reset applied with no clock: y follows inputs, registers cleared.
        rst = 1'b1; a = 4'b0111; b = 4'b1000; sel = 1'b0;
        reset_model();
        #1;
        chk("rst_yq", 32'(y_q), 32'(m_yq));
        chk("rst_selq", 32'(sel_q), 32'(m_selq));
        #9;
        chk("y_sel0", 32'(y), 32'h7);

        rst = 1'b0;
        a = 4'b0011; b = 4'b1000; sel = 1'b1;
        #10;
        chk("y_sel1", 32'(y), 32'h8);

        // Toggle select with no clock running.
        a = 4'hF; b = 4'h0;
        sel = 1'b0; #1 chk("tog0", 32'(y), 32'hF);
        sel = 1'b1; #1 chk("tog1", 32'(y), 32'h0);
        sel = 1'b0; #1 chk("tog2", 32'(y), 32'hF);
        chk("noclk_yq", 32'(y_q), 32'h0);

        // rst does not gate y; registers clear at once.
        rst = 1'b1; a = 4'h5; sel = 1'b0;
        #1;
        chk("rst_y", 32'(y), 32'h5);
        chk("rst_yq2", 32'(y_q), 32'h0);
        chk("rst_selq2", 32'(sel_q), 32'h0);
        rst = 1'b0;

        // Single capture, then comb path changes while register holds.
        a = 4'h3; b = 4'hC; sel = 1'b1;
        tick();
        chk("cap_yq", 32'(y_q), 32'hC);
        chk("cap_selq", 32'(sel_q), 32'h1);
        sel = 1'b0;
        #1;
        chk("hold_y", 32'(y), 32'h3);
        chk("hold_yq", 32'(y_q), 32'hC);

        // Async reset between edges; release waits for next edge.
        #1 rst = 1'b1;
        reset_model();
        #1;
        chk("mid_rst_yq", 32'(y_q), 32'h0);
        chk("mid_rst_selq", 32'(sel_q), 32'h0);
        rst = 1'b0;
        #1;
        chk("rel_yq", 32'(y_q), 32'h0);
        tick();
        chk("rel_cap_yq", 32'(y_q), 32'h3);
        chk("rel_cap_selq", 32'(sel_q), 32'h0);

        // Edge while reset is held: no capture.
        rst = 1'b1; b = 4'hA; sel = 1'b1;
        tick();
        chk("held_yq", 32'(y_q), 32'h0);
        chk("held_selq", 32'(sel_q), 32'h0);
        rst = 1'b0;

        // Random traffic with occasional held or mid-cycle resets.
        for (int i = 0; i < 300; i++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            sel = 1'($urandom);
            rst = ($urandom_range(0, 9) == 0);
            #1;
            chk("rnd_y", 32'(y), 32'(pick(a, b, sel)));
            tick();
            chk("rnd_yq", 32'(y_q), 32'(m_yq));
            chk("rnd_selq", 32'(sel_q), 32'(m_selq));
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                reset_model();
                #1;
                chk("rnd_async", 32'(y_q), 32'(m_yq));
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
